// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter and its
// round-robin selector.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefBurstLen = 4;
  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned BurstCntW   = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer request lanes plus FIFO write port, grouped for the arbiter.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned DATA_W  = DefDataW
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_data;
  logic                      fifo_full;

  modport master (
    input  req, req_data, fifo_full,
    output ack, grant, busy, fifo_wr, fifo_data
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, grant, busy, fifo_wr, fifo_data
  );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: searches last_owner+1, +2, ... modulo
// NUM_REQ and returns the first asserted request.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdxW   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last_owner,
  output logic [IdxW-1:0]    winner,
  output logic               any_req
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_owner) + off) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter driving the single write port of the byte FIFO.
// Each grant carries at most BURST_LEN words and is always followed by one idle cycle.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned BURST_LEN = DefBurstLen
) (
  input logic                  clk,
  input logic                  rst,
  fifo_write_arbiter_if.master bus
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);
  // A 4-bit counter cannot hold 16; the grant ends at BURST_LEN-1 anyway.
  localparam int unsigned CntMax = (BURST_LEN < 15) ? BURST_LEN : 15;
  localparam logic [BurstCntW-1:0] LastBeat = BurstCntW'(BURST_LEN - 1);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [IdxW-1:0]      last_owner_q, last_owner_d;
  logic [BurstCntW-1:0] burst_cnt_q, burst_cnt_d;

  logic [IdxW-1:0]    winner;
  logic               any_req;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_req;
  logic               xfer;

  fifo_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (bus.req),
    .last_owner(last_owner_q),
    .winner    (winner),
    .any_req   (any_req)
  );

  assign owner_oh  = NUM_REQ'(1) << owner_q;
  assign owner_req = bus.req[owner_q];
  // Gating with rst keeps a partial word out of the FIFO during a reset cycle.
  assign xfer      = (state_q == StGrant) && owner_req && !bus.fifo_full && !rst;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d      = winner;
          last_owner_d = winner;
          burst_cnt_d  = '0;
          state_d      = StGrant;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          state_d = StIdle;
        end else if (xfer) begin
          if (32'(burst_cnt_q) < CntMax) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
          if (burst_cnt_q == LastBeat) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.grant     = '0;
    bus.busy      = 1'b0;
    bus.ack       = '0;
    bus.fifo_wr   = 1'b0;
    bus.fifo_data = '0;
    if (state_q == StGrant) begin
      bus.grant     = owner_oh;
      bus.busy      = 1'b1;
      bus.fifo_data = bus.req_data[32'(owner_q)*DATA_W +: DATA_W];
      bus.fifo_wr   = xfer;
      bus.ack       = xfer ? owner_oh : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IdxW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-producer word queues, a cycle-level
// behavioural model of the grant rules, and directed plus random scenarios.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned N  = DefNumReq;
  localparam int unsigned W  = DefDataW;
  localparam int unsigned BL = DefBurstLen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (W),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] pq [N][$];
  bit           en [N];
  bit           full_v;
  bit           rst_v;

  // Model: who owns the port, who owned it last, words taken this grant.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_cnt;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  logic [N-1:0] gseq  [$];
  logic [N-1:0] obs_grant;
  logic [N-1:0] prev_grant = '0;
  logic         obs_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_cnt   = 0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle();
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    logic [N-1:0]   oh;
    bit             xfer;
    @(negedge clk);
    r = '0;
    for (int i = 0; i < N; i++) begin
      d[i*W +: W] = W'($urandom);
      if (en[i] && pq[i].size() > 0) begin
        r[i]        = 1'b1;
        d[i*W +: W] = pq[i][0];
      end
    end
    rst           = rst_v;
    bus.req       = r;
    bus.req_data  = d;
    bus.fifo_full = full_v;
    #1;
    oh   = m_busy ? (N'(1) << m_owner) : '0;
    xfer = m_busy && r[m_owner] && !full_v && !rst_v;
    chk("grant", 32'(bus.grant), 32'(oh));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("ack", 32'(bus.ack), xfer ? 32'(oh) : 32'd0);
    chk("fifo_wr", 32'(bus.fifo_wr), 32'(xfer));
    chk("fifo_data", 32'(bus.fifo_data), m_busy ? 32'(d[m_owner*W +: W]) : 32'd0);
    obs_grant = bus.grant;
    obs_wr    = bus.fifo_wr;
    if (bus.fifo_wr) got_q.push_back(bus.fifo_data);
    if (bus.grant != '0 && prev_grant == '0) gseq.push_back(bus.grant);
    prev_grant = bus.grant;
    if (xfer) exp_q.push_back(pq[m_owner].pop_front());
    if (rst_v) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (r[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_last  = m_owner;
          m_busy  = 1'b1;
          m_cnt   = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
    end else if (xfer) begin
      m_cnt++;
      if (m_cnt == BL) m_busy = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    gseq.delete();
  endtask

  task automatic drain();
    int budget = 400;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    full_v = 1'b0;
    while (budget > 0 && (pending() || m_busy)) begin
      cycle();
      budget--;
    end
    chk("drain_done", 32'(pending() || m_busy), 32'd0);
  endtask

  task automatic compare_fifo(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_model(input int owner, input int cnt, input string tag);
    int b = 0;
    while (b < 50 && !(m_busy && m_owner == owner && m_cnt == cnt)) begin
      cycle();
      b++;
    end
    chk(tag, 32'(m_busy && m_owner == owner && m_cnt == cnt), 32'd1);
  endtask

  initial begin
    logic [N-1:0] fair_exp [4];
    fair_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    model_reset();
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    full_v = 1'b0;
    rst_v  = 1'b1;
    cycle();
    cycle();
    rst_v = 1'b0;
    gseq.delete();

    // Single producer, six words, burst split 4 + 2.
    for (int i = 0; i < 6; i++) pq[1].push_back(W'(8'hA0 + i));
    drain();
    chk("s1_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < got_q.size() && i < 6; i++) chk("s1_word", 32'(got_q[i]), 32'hA0 + i);
    chk("s1_grants", 32'(gseq.size()), 32'd2);
    compare_fifo("s1");

    // Fairness between producers 0 and 2.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pq[0].push_back(W'(8'h10 + i));
      pq[2].push_back(W'(8'h20 + i));
    end
    drain();
    chk("s2_grants", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < gseq.size() && i < 4; i++) chk("s2_order", 32'(gseq[i]), 32'(fair_exp[i]));
    compare_fifo("s2");

    // Backpressure after producer 3's first word.
    do_reset();
    for (int i = 0; i < 4; i++) pq[3].push_back(W'(8'hB0 + i));
    wait_model(3, 1, "s3_reach");
    full_v = 1'b1;
    repeat (5) begin
      cycle();
      chk("s3_stall_wr", 32'(obs_wr), 32'd0);
      chk("s3_hold", 32'(obs_grant), 32'b1000);
    end
    drain();
    chk("s3_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size() && i < 4; i++) chk("s3_word", 32'(got_q[i]), 32'hB0 + i);
    compare_fifo("s3");

    // Early release by producer 0 with producer 1 waiting.
    do_reset();
    for (int i = 0; i < 4; i++) pq[0].push_back(W'(8'hC0 + i));
    pq[1].push_back(8'hD0);
    pq[1].push_back(8'hD1);
    wait_model(0, 2, "s4_reach");
    en[0] = 1'b0;
    cycle();
    chk("s4_rel_nowr", 32'(obs_wr), 32'd0);
    cycle();
    chk("s4_idle", 32'(obs_grant), 32'd0);
    cycle();
    chk("s4_regrant", 32'(obs_grant), 32'b0010);
    drain();
    compare_fifo("s4");

    // Reset during producer 2's third word.
    do_reset();
    en[0] = 1'b0;
    pq[0].push_back(8'hE0);
    pq[0].push_back(8'hE1);
    for (int i = 0; i < 4; i++) pq[2].push_back(W'(8'hF0 + i));
    wait_model(2, 2, "s5_reach");
    en[0] = 1'b1;
    rst_v = 1'b1;
    cycle();
    chk("s5_rst_nowr", 32'(obs_wr), 32'd0);
    rst_v = 1'b0;
    cycle();
    chk("s5_post_rst", 32'(obs_grant), 32'd0);
    cycle();
    chk("s5_winner", 32'(obs_grant), 32'b0001);
    drain();
    compare_fifo("s5");

    // Owner releases while the FIFO is full.
    do_reset();
    for (int i = 0; i < 3; i++) pq[1].push_back(W'(8'h50 + i));
    wait_model(1, 1, "s6_reach");
    en[1]  = 1'b0;
    full_v = 1'b1;
    cycle();
    chk("s6_nowr", 32'(obs_wr), 32'd0);
    cycle();
    chk("s6_idle", 32'(obs_grant), 32'd0);
    drain();
    compare_fifo("s6");

    // Random traffic, stalls, gaps and occasional resets.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 1) == 0) pq[$urandom_range(0, N - 1)].push_back(W'($urandom));
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 7) != 0);
      full_v = ($urandom_range(0, 3) == 0);
      rst_v  = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst_v = 1'b0;
    drain();
    compare_fifo("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
